// File: rtl/freq_div_pkg.sv
// Shared types and defaults for the divider configuration controller.
package freq_div_pkg;

    localparam int DIV_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        LOAD,
        HOLD,
        DONE_ACK,
        DONE_NACK
    } state_t;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/freq_div_cfg_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int PTR_W = $clog2(NUM_REQ);

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (PTR_W'(i) >= ptr)) begin
                any             = 1'b1;
                grant_idx       = PTR_W'(i);
                grant_onehot[i] = 1'b1;
            end
        end
        // Wrap-around pass: nothing at or above ptr, so take the lowest set bit.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any             = 1'b1;
                grant_idx       = PTR_W'(i);
                grant_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/freq_div_cfg_ctrl.sv
// Shares one programmable divider between NUM_REQ clients, reprogramming it
// with a disable -> settle -> load -> re-enable sequence.
//
//   state     | meaning
//   IDLE      | divider running (if Run), waiting for a request
//   QUIESCE   | Enable held low, SETTLE-cycle down-count
//   LOAD      | drive Din and pulse ConfigDiv
//   HOLD      | Din held, ActiveDiv takes the new divisor
//   DONE_ACK  | pulse Ack to the winner, advance RR pointer
//   DONE_NACK | pulse Nack to the winner (divisor 0), advance RR pointer
module freq_div_cfg_ctrl
    import freq_div_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DIV_W   = DIV_W_DEFAULT,
    parameter int SETTLE  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*DIV_W-1:0] ReqDiv,
    output logic [NUM_REQ-1:0]       Ack,
    output logic [NUM_REQ-1:0]       Nack,
    output logic [DIV_W-1:0]         DivDin,
    output logic                     DivConfigDiv,
    output logic                     DivEnable,
    output logic [DIV_W-1:0]         ActiveDiv,
    output logic                     Busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SETTLE + 1);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, ptr_nxt, grant_idx, win_idx;
    logic [NUM_REQ-1:0] grant_oh, win_oh;
    logic               any_req, reload, quiet;
    logic [DIV_W-1:0]   sel_div, win_div;
    logic [CNT_W-1:0]   settle_cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req          (Req),
        .ptr          (rr_ptr),
        .grant_onehot (grant_oh),
        .grant_idx    (grant_idx),
        .any          (any_req)
    );

    always_comb begin
        sel_div = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) sel_div = ReqDiv[i*DIV_W +: DIV_W];
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign Busy    = (state != IDLE);

    // Enable stays up across fast-path acks and nacks; only a real reload drops it.
    assign quiet = (state == QUIESCE) || (state == LOAD) || (state == HOLD) ||
                   ((state == DONE_ACK) && reload);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (sel_div == '0)            state_nxt = DONE_NACK;
                    else if (sel_div == ActiveDiv) state_nxt = DONE_ACK;
                    else                          state_nxt = QUIESCE;
                end
            end
            QUIESCE:   if (settle_cnt == '0) state_nxt = LOAD;
            LOAD:      state_nxt = HOLD;
            HOLD:      state_nxt = DONE_ACK;
            DONE_ACK:  state_nxt = IDLE;
            DONE_NACK: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Ack          <= '0;
            Nack         <= '0;
            DivDin       <= '0;
            DivConfigDiv <= 1'b0;
            DivEnable    <= 1'b0;
            ActiveDiv    <= '0;
            rr_ptr       <= '0;
            win_idx      <= '0;
            win_oh       <= '0;
            win_div      <= '0;
            reload       <= 1'b0;
            settle_cnt   <= '0;
        end else begin
            Ack          <= '0;
            Nack         <= '0;
            DivConfigDiv <= 1'b0;
            DivEnable    <= Run && (ActiveDiv != '0) && !quiet;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_idx    <= grant_idx;
                        win_oh     <= grant_oh;
                        win_div    <= sel_div;
                        reload     <= (sel_div != '0) && (sel_div != ActiveDiv);
                        settle_cnt <= CNT_W'(SETTLE - 1);
                    end
                end
                QUIESCE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                LOAD: begin
                    DivDin       <= win_div;
                    DivConfigDiv <= 1'b1;
                end
                HOLD:      ActiveDiv <= win_div;
                DONE_ACK: begin
                    Ack    <= win_oh;
                    rr_ptr <= ptr_nxt;
                end
                DONE_NACK: begin
                    Nack   <= win_oh;
                    rr_ptr <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_div_cfg_ctrl.sv
// Self-checking bench for freq_div_cfg_ctrl: scoreboard on Ack/Nack plus
// per-request timing checks of the divider pins.
module tb_freq_div_cfg_ctrl;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int S  = 4;

    logic             Clk = 1'b0;
    logic             Reset, Run;
    logic [NR-1:0]    Req;
    logic [NR*DW-1:0] ReqDiv;
    logic [NR-1:0]    Ack, Nack;
    logic [DW-1:0]    DivDin, ActiveDiv;
    logic             DivConfigDiv, DivEnable, Busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] model_active;

    typedef struct {
        bit            nack;
        int            idx;
        logic [DW-1:0] active;
    } exp_t;
    exp_t sb[$];

    freq_div_cfg_ctrl #(.NUM_REQ(NR), .DIV_W(DW), .SETTLE(S)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .Req          (Req),
        .ReqDiv       (ReqDiv),
        .Ack          (Ack),
        .Nack         (Nack),
        .DivDin       (DivDin),
        .DivConfigDiv (DivConfigDiv),
        .DivEnable    (DivEnable),
        .ActiveDiv    (ActiveDiv),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin : mon
        exp_t e;
        logic [NR-1:0] ev;
        if (!Reset && (Ack != '0 || Nack != '0)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 64'({Nack, Ack}), 64'd0);
            end else begin
                e  = sb.pop_front();
                ev = NR'(1) << e.idx;
                check("sb_ack", Ack, e.nack ? '0 : ev);
                check("sb_nack", Nack, e.nack ? ev : '0);
                check("sb_active", ActiveDiv, e.active);
            end
        end
    end

    task automatic req_and_check(input int idx, input logic [DW-1:0] div,
                                 input string tag, input int toggle_at);
        bit fast, got, busy1;
        int exp_lat, exp_low, k, cfg_cnt, cfg_at, en_low;
        logic [DW-1:0] cfg_din;
        fast    = (div == '0) || (div == model_active);
        exp_lat = fast ? 2 : S + 4;
        if (model_active == '0) exp_low = exp_lat;
        else                    exp_low = fast ? 0 : S + 3;
        sb.push_back('{(div == '0), idx, (div == '0) ? model_active : div});
        Req[idx] = 1'b1;
        ReqDiv[idx*DW +: DW] = div;
        k = 0; got = 0; busy1 = 0; cfg_cnt = 0; cfg_at = 0; en_low = 0; cfg_din = '0;
        while (!got && k < 60) begin
            @(negedge Clk);
            k++;
            if (k == 1) busy1 = Busy;
            if (DivConfigDiv) begin
                cfg_cnt++;
                cfg_at  = k;
                cfg_din = DivDin;
            end
            if (!DivEnable) en_low++;
            if (Ack != '0 || Nack != '0) got = 1;
            if (k == toggle_at)          Run = 1'b0;
            else if (k == toggle_at + 1) Run = 1'b1;
        end
        Req[idx] = 1'b0;
        if (div != '0) model_active = div;
        check({tag, "_lat"}, got ? k : 999, exp_lat);
        check({tag, "_busy"}, busy1, 1);
        check({tag, "_cfg_cnt"}, cfg_cnt, fast ? 0 : 1);
        if (!fast) begin
            check({tag, "_cfg_at"}, cfg_at, S + 2);
            check({tag, "_cfg_din"}, cfg_din, div);
        end
        check({tag, "_en_low"}, en_low, exp_low);
        @(negedge Clk);
        check({tag, "_en_after"}, DivEnable, Run && (model_active != '0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k, first, second, acks, cfg_cnt;
        bit prev, overlap;
        Reset = 1'b1; Run = 1'b1; Req = '0; ReqDiv = '0; model_active = '0;
        repeat (3) @(negedge Clk);
        check("rst_ctrl", {Ack, Nack, DivConfigDiv, DivEnable, Busy}, 0);
        check("rst_din", DivDin, 0);
        check("rst_active", ActiveDiv, 0);
        Reset = 1'b0;
        @(negedge Clk);

        req_and_check(0, 32'd10, "t1", -1);
        req_and_check(0, 32'd10, "t4_fast", -1);
        req_and_check(1, 32'd0,  "t3_nack", -1);
        check("t3_active", ActiveDiv, 10);

        // Both clients at once, pointer at 0: client0 first, then client1.
        sb.push_back('{1'b0, 0, 32'd6});
        sb.push_back('{1'b0, 1, 32'd8});
        ReqDiv = {32'd8, 32'd6};
        Req = 2'b11;
        k = 0; first = 0; second = 0; acks = 0; cfg_cnt = 0; prev = 0; overlap = 0;
        while (acks < 2 && k < 100) begin
            @(negedge Clk);
            k++;
            if (DivConfigDiv) begin
                cfg_cnt++;
                if (prev) overlap = 1;
            end
            prev = DivConfigDiv;
            if (Ack[0]) begin Req[0] = 1'b0; first = k; acks++; end
            if (Ack[1]) begin Req[1] = 1'b0; second = k; acks++; end
        end
        Req = '0;
        model_active = 32'd8;
        check("t2_first_lat", first, S + 4);
        check("t2_second_gap", second - first, S + 4);
        check("t2_cfg_cnt", cfg_cnt, 2);
        check("t2_overlap", overlap, 0);
        check("t2_active", ActiveDiv, 8);

        req_and_check(0, 32'd5, "t6_load", -1);
        Run = 1'b0;
        @(negedge Clk);
        check("t6_run0", DivEnable, 0);
        Run = 1'b1;
        @(negedge Clk);
        check("t6_run1", DivEnable, 1);
        req_and_check(1, 32'd7, "t6_toggle", S + 1);
        req_and_check(0, 32'd1, "div1", -1);
        req_and_check(1, 32'hFFFF_FFFF, "wide", -1);

        // Reset while the sequence sits in QUIESCE.
        ReqDiv[DW-1:0] = 32'd12;
        Req[0] = 1'b1;
        repeat (2) @(negedge Clk);
        check("t5_busy_pre", Busy, 1);
        Reset = 1'b1;
        #1;
        check("t5_rst_ctrl", {Ack, Nack, DivConfigDiv, DivEnable, Busy}, 0);
        check("t5_rst_active", ActiveDiv, 0);
        Req = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        model_active = '0;
        @(negedge Clk);
        req_and_check(0, 32'd12, "t5_rerun", -1);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
